smart_rst_seq: RTL and testbench

SMART_RST_SEQ -- requirements
Module: smart_rst_seq

---
 rtl/smart_pkg.sv | 24 ++
 rtl/smart_sat_cnt.sv | 22 ++
 rtl/smart_rst_seq.sv | 100 ++++++++++
 tb/tb_smart_rst_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/smart_pkg.sv
// Shared definitions for the smart reset sequencer and the memory access controller.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package smart_pkg;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WIPE    = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Protected region bounds shared with the access controller
    localparam int DEF_LOW_SAFE  = 200;
    localparam int DEF_HIGH_SAFE = 200;

    // Width of the violation counter
    localparam int VIOL_CNT_W = 8;

    // Saturating increment: holds at all-ones
    function automatic logic [VIOL_CNT_W-1:0] sat_inc(input logic [VIOL_CNT_W-1:0] v);
        return (v == {VIOL_CNT_W{1'b1}}) ? v : v + VIOL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/smart_sat_cnt.sv
// Saturating event counter with enable and synchronous clear.
// Latency: count updates on the edge where en is sampled high.
// Backpressure: none; clear has priority over enable, holds at max.
module smart_sat_cnt
    import smart_pkg::*;
(
    input  logic                  mclk,
    input  logic                  clr,
    input  logic                  en,
    output logic [VIOL_CNT_W-1:0] cnt
);

    // Clear wins; otherwise count enabled events and stick at the top value
    always_ff @(posedge mclk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/smart_rst_seq.sv
// Violation-triggered secure reset: wipe the protected region, hold reset, release.
// Latency: outputs assert the cycle after an accepted violation; hold lasts HOLD_CYCLES.
// Backpressure: wipe stalls indefinitely while wipe_gnt is low; requests ignored while busy.
module smart_rst_seq
    import smart_pkg::*;
#(
    parameter int SIZE_MEM_ADDR = 15,
    parameter int LOW_SAFE      = DEF_LOW_SAFE,
    parameter int HIGH_SAFE     = DEF_HIGH_SAFE,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic                   mclk,
    input  logic                   puc_rst,
    input  logic                   viol_req,
    input  logic [15:0]            viol_addr,
    input  logic                   disable_debug,
    input  logic                   wipe_gnt,
    output logic                   wipe_wen,
    output logic [SIZE_MEM_ADDR:0] wipe_addr,
    output logic [15:0]            wipe_din,
    output logic                   sys_rst,
    output logic                   busy,
    output logic [VIOL_CNT_W-1:0]  viol_cnt,
    output logic [15:0]            last_viol_addr
);

    localparam int AW = SIZE_MEM_ADDR + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    localparam logic [AW-1:0] ADDR_LO   = AW'(LOW_SAFE);
    localparam logic [AW-1:0] ADDR_HI   = AW'(HIGH_SAFE);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;
    logic          accept;

    // A violation is only taken from IDLE and only while debug gating is off
    assign accept = (state == ST_IDLE) && viol_req && !disable_debug;

    // Sequencer: IDLE -> WIPE (one granted write per word) -> HOLD -> RELEASE -> IDLE
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state          <= ST_IDLE;
            wipe_addr      <= ADDR_LO;
            hold_cnt       <= '0;
            last_viol_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state          <= ST_WIPE;
                        wipe_addr      <= ADDR_LO;
                        last_viol_addr <= viol_addr;
                    end
                end
                ST_WIPE: begin
                    // Without a grant the address simply holds; there is no timeout
                    if (wipe_gnt) begin
                        if (wipe_addr == ADDR_HI) begin
                            state    <= ST_HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end else begin
                            wipe_addr <= wipe_addr + AW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                ST_RELEASE: begin
                    // One reset-free cycle so a level-held request is re-evaluated in IDLE
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Accepted violations, cleared by power-up reset
    smart_sat_cnt u_viol_cnt (
        .mclk (mclk),
        .clr  (puc_rst),
        .en   (accept),
        .cnt  (viol_cnt)
    );

    // Outputs decoded straight from the registered state
    assign wipe_wen = (state == ST_WIPE);
    assign sys_rst  = (state == ST_WIPE) || (state == ST_HOLD);
    assign busy     = (state != ST_IDLE);
    assign wipe_din = 16'h0000;

endmodule

// File: tb/tb_smart_rst_seq.sv
// Scoreboard bench for smart_rst_seq: stimulus queues expected writes and sequence summaries.
// Latency: checks sampled on the falling edge; inputs driven 1 time unit after rising edge.
// Backpressure: wipe_gnt driven fixed, stalled, or random per sequence.
module tb_smart_rst_seq;

    localparam int LOW  = 200;
    localparam int HIGH = 203;
    localparam int HOLD = 4;
    localparam int NWR  = HIGH - LOW + 1;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        viol_req;
    logic [15:0] viol_addr;
    logic        disable_debug;
    logic        wipe_gnt;
    logic        wipe_wen;
    logic [15:0] wipe_addr;
    logic [15:0] wipe_din;
    logic        sys_rst;
    logic        busy;
    logic [7:0]  viol_cnt;
    logic [15:0] last_viol_addr;

    smart_rst_seq #(
        .SIZE_MEM_ADDR (15),
        .LOW_SAFE      (LOW),
        .HIGH_SAFE     (HIGH),
        .HOLD_CYCLES   (HOLD)
    ) dut (
        .mclk           (mclk),
        .puc_rst        (puc_rst),
        .viol_req       (viol_req),
        .viol_addr      (viol_addr),
        .disable_debug  (disable_debug),
        .wipe_gnt       (wipe_gnt),
        .wipe_wen       (wipe_wen),
        .wipe_addr      (wipe_addr),
        .wipe_din       (wipe_din),
        .sys_rst        (sys_rst),
        .busy           (busy),
        .viol_cnt       (viol_cnt),
        .last_viol_addr (last_viol_addr)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [7:0]  cnt;
        logic [15:0] addr;
        int          wc;
    } seq_t;

    int          total = 0;
    int          bad   = 0;
    int          exp_wr[$];
    seq_t        exp_seq[$];
    int          exp_cnt = 0;
    int          wen_cyc = 0;
    int          rst_cyc = 0;
    seq_t        mon_s;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop expected write addresses on granted writes, sequence summary on RELEASE
    always @(negedge mclk) begin
        if (puc_rst) begin
            wen_cyc = 0;
            rst_cyc = 0;
        end else begin
            if (wipe_wen) begin
                wen_cyc++;
                chk("wipe_din", wipe_din, 0);
            end
            if (sys_rst) rst_cyc++;
            if (wipe_wen && wipe_gnt) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
                else chk("wr_addr", wipe_addr, exp_wr.pop_front());
            end
            if (busy && !sys_rst) begin
                if (exp_seq.size() == 0) begin
                    chk("unexpected_release", 1, 0);
                end else begin
                    mon_s = exp_seq.pop_front();
                    chk("wipe_cycles", wen_cyc, mon_s.wc);
                    chk("rst_cycles", rst_cyc, mon_s.wc + HOLD);
                    chk("viol_cnt", viol_cnt, mon_s.cnt);
                    chk("last_viol_addr", last_viol_addr, mon_s.addr);
                end
            end
            if (!busy || (busy && !sys_rst)) begin
                wen_cyc = 0;
                rst_cyc = 0;
            end
        end
    end

    // One complete violation sequence; entered and left 1 unit after an edge with DUT idle.
    // mode 0: always grant, 1: three stalls at the second word, 2: random grants
    task automatic run_seq(input logic [15:0] a, input int mode, input bit hold_req, input bit dbg_mid);
        int writes = 0;
        int wc     = 0;
        int stalls = 0;
        bit g;
        viol_req      = 1'b1;
        viol_addr     = a;
        disable_debug = 1'b0;
        wipe_gnt      = 1'($urandom_range(0, 1));
        if (exp_cnt < 255) exp_cnt++;
        for (int i = 0; i < NWR; i++) exp_wr.push_back(LOW + i);
        @(posedge mclk); #1;
        if (!hold_req) viol_req = 1'b0;
        viol_addr = 16'($urandom);
        if (dbg_mid) disable_debug = 1'b1;
        while (writes < NWR) begin
            case (mode)
                0: g = 1'b1;
                1: begin
                    if (writes == 1 && stalls < 3) begin
                        g = 1'b0;
                        stalls++;
                        chk("stall_addr", wipe_addr, LOW + 1);
                        chk("stall_wen", wipe_wen, 1);
                    end else begin
                        g = 1'b1;
                    end
                end
                default: g = 1'($urandom_range(0, 1));
            endcase
            wipe_gnt = g;
            @(posedge mclk); #1;
            wc++;
            if (g) writes++;
        end
        exp_seq.push_back('{cnt: 8'(exp_cnt), addr: a, wc: wc});
        wipe_gnt = 1'($urandom_range(0, 1));
        repeat (HOLD) begin @(posedge mclk); #1; end
        @(posedge mclk); #1;
        disable_debug = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        puc_rst = 1'b1; viol_req = 1'b0; viol_addr = '0; disable_debug = 1'b0; wipe_gnt = 1'b0;
        repeat (3) @(posedge mclk);
        #1 puc_rst = 1'b0;
        chk("rst_sys_rst", sys_rst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wen", wipe_wen, 0);
        chk("rst_addr", wipe_addr, LOW);
        chk("rst_din", wipe_din, 0);
        chk("rst_cnt", viol_cnt, 0);
        chk("rst_last", last_viol_addr, 0);

        // Basic violation with continuous grant
        run_seq(16'h4A10, 0, 1'b0, 1'b0);
        chk("basic_idle", busy, 0);

        // Debug bypass
        disable_debug = 1'b1; viol_req = 1'b1; viol_addr = 16'hBEEF;
        @(posedge mclk); #1;
        viol_req = 1'b0;
        @(posedge mclk); #1;
        chk("dbg_busy", busy, 0);
        chk("dbg_sys_rst", sys_rst, 0);
        chk("dbg_cnt", viol_cnt, exp_cnt);
        chk("dbg_last", last_viol_addr, 16'h4A10);
        disable_debug = 1'b0;

        // Stalled grant at the second word
        run_seq(16'h1357, 1, 1'b0, 1'b0);
        // Debug gating rising mid-sequence, then random grants
        run_seq(16'($urandom), 2, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) run_seq(16'($urandom), 2, 1'b0, 1'b0);

        // Reset at the second wipe cycle
        viol_req = 1'b1; viol_addr = 16'h1234; wipe_gnt = 1'b1;
        for (int i = 0; i < NWR; i++) exp_wr.push_back(LOW + i);
        @(posedge mclk); #1;
        viol_req = 1'b0;
        @(posedge mclk); #1;
        puc_rst = 1'b1; wipe_gnt = 1'b0;
        exp_wr.delete();
        @(posedge mclk); #1;
        puc_rst = 1'b0; exp_cnt = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_sys_rst", sys_rst, 0);
        chk("midrst_wen", wipe_wen, 0);
        chk("midrst_addr", wipe_addr, LOW);
        chk("midrst_cnt", viol_cnt, 0);
        chk("midrst_last", last_viol_addr, 0);

        // Reset and violation together
        run_seq(16'h0F0F, 0, 1'b0, 1'b0);
        viol_req = 1'b1; puc_rst = 1'b1; viol_addr = 16'hAAAA;
        @(posedge mclk); #1;
        viol_req = 1'b0; puc_rst = 1'b0; exp_cnt = 0;
        chk("simul_cnt", viol_cnt, 0);
        chk("simul_busy", busy, 0);
        chk("simul_last", last_viol_addr, 0);

        // Level-held request: back-to-back sequences through saturation
        for (int i = 0; i < 300; i++) run_seq(16'($urandom), 2, 1'b1, 1'b0);
        viol_req = 1'b0;
        @(posedge mclk); #1;
        chk("sat_cnt", viol_cnt, 255);
        chk("sat_idle", busy, 0);
        run_seq(16'h5A5A, 0, 1'b0, 1'b0);
        @(posedge mclk); #1;
        chk("sat_hold", viol_cnt, 255);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("seq_queue_empty", exp_seq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
